// File: rtl/pmu_pkg.sv
// Shared PMU constants: default counter geometry and the write-address width helper,
// also used by the quota stage.
package pmu_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int N_COUNTERS = 9;

  // Never narrower than one bit, so a single-counter bank still has an address port.
  function automatic int pmu_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ADDR_W = pmu_addr_w(N_COUNTERS);

endpackage

// File: rtl/pmu_counter_cell.sv
// One wrap-around event counter with software preset and a sticky overflow flag.
// Priority: soft reset, then write, then increment, then hold.
module pmu_counter_cell
  import pmu_pkg::*;
#(
  parameter int W = REG_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         softrst_i,
  input  logic         inc_i,
  input  logic         wr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         ovf_clr_i,
  output logic [W-1:0] value_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] value_q, value_d;
  logic         ovf_q, ovf_d;
  logic         wrap;

  always_comb begin
    wrap    = 1'b0;
    value_d = value_q;
    ovf_d   = ovf_q;
    if (softrst_i) begin
      value_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (wr_i) begin
        value_d = wdata_i;
      end else if (inc_i) begin
        value_d = value_q + ONE;
        wrap    = (value_q == '1);
      end
      // A wrap in the same cycle as a clear keeps the flag set.
      if (wrap) begin
        ovf_d = 1'b1;
      end else if (ovf_clr_i) begin
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value_o = value_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pmu_event_counters.sv
// PMU event-counter bank: registers event strobes, counts them in parallel counters,
// and raises a masked interrupt from the sticky overflow flags.
module pmu_event_counters
  import pmu_pkg::*;
#(
  parameter  int REG_WIDTH  = pmu_pkg::REG_WIDTH,
  parameter  int N_COUNTERS = pmu_pkg::N_COUNTERS,
  localparam int ADDR_W     = pmu_addr_w(N_COUNTERS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  softrst_i,
  input  logic                  en_i,
  input  logic [N_COUNTERS-1:0] events_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [REG_WIDTH-1:0]  wdata_i,
  input  logic [N_COUNTERS-1:0] ovf_clr_i,
  input  logic [N_COUNTERS-1:0] ovf_mask_i,
  output logic [REG_WIDTH-1:0]  counter_value_o [0:N_COUNTERS-1],
  output logic [N_COUNTERS-1:0] overflow_o,
  output logic                  intr_overflow_o
);

  logic [N_COUNTERS-1:0] ev_q;
  logic [N_COUNTERS-1:0] wr_sel;
  logic [N_COUNTERS-1:0] inc;
  logic                  intr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ev_q <= '0;
    end else if (softrst_i) begin
      ev_q <= '0;
    end else begin
      ev_q <= events_i;
    end
  end

  // Addresses at or above N_COUNTERS match no cell, so such writes are dropped.
  for (genvar n = 0; n < N_COUNTERS; n++) begin : g_cell
    assign wr_sel[n] = we_i && (waddr_i == ADDR_W'(n));
    assign inc[n]    = en_i && ev_q[n];

    pmu_counter_cell #(
      .W(REG_WIDTH)
    ) u_cell (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .softrst_i (softrst_i),
      .inc_i     (inc[n]),
      .wr_i      (wr_sel[n]),
      .wdata_i   (wdata_i),
      .ovf_clr_i (ovf_clr_i[n]),
      .value_o   (counter_value_o[n]),
      .ovf_o     (overflow_o[n])
    );
  end

  // Registered from the current flags, so the interrupt trails the flag by one edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      intr_q <= 1'b0;
    end else if (softrst_i) begin
      intr_q <= 1'b0;
    end else begin
      intr_q <= |(overflow_o & ovf_mask_i);
    end
  end

  assign intr_overflow_o = intr_q;

endmodule

// File: tb/tb_pmu_event_counters.sv
// Directed and randomized checks of pmu_event_counters against a cycle-level model
// built from the counting rules.
module tb_pmu_event_counters;
  import pmu_pkg::*;

  localparam int W  = REG_WIDTH;
  localparam int N  = N_COUNTERS;
  localparam int AW = ADDR_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic          softrst_i = 1'b0;
  logic          en_i = 1'b0;
  logic [N-1:0]  events_i = '0;
  logic          we_i = 1'b0;
  logic [AW-1:0] waddr_i = '0;
  logic [W-1:0]  wdata_i = '0;
  logic [N-1:0]  ovf_clr_i = '0;
  logic [N-1:0]  ovf_mask_i = '0;
  logic [W-1:0]  counter_value_o [0:N-1];
  logic [N-1:0]  overflow_o;
  logic          intr_overflow_o;

  pmu_event_counters dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .softrst_i       (softrst_i),
    .en_i            (en_i),
    .events_i        (events_i),
    .we_i            (we_i),
    .waddr_i         (waddr_i),
    .wdata_i         (wdata_i),
    .ovf_clr_i       (ovf_clr_i),
    .ovf_mask_i      (ovf_mask_i),
    .counter_value_o (counter_value_o),
    .overflow_o      (overflow_o),
    .intr_overflow_o (intr_overflow_o)
  );

  int checks = 0;
  int failures = 0;

  // reference model: counts as plain integers, events delayed one cycle
  longint unsigned m_cnt [N];
  logic [N-1:0]    m_ovf;
  logic [N-1:0]    m_pending;
  logic            m_intr;

  task automatic model_clear();
    for (int n = 0; n < N; n++) m_cnt[n] = 0;
    m_ovf = '0;
    m_pending = '0;
    m_intr = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] new_ovf;
    logic         new_intr;
    new_intr = (|(m_ovf & ovf_mask_i)) && !softrst_i;
    new_ovf  = m_ovf;
    for (int n = 0; n < N; n++) begin
      bit wrapped;
      wrapped = 1'b0;
      if (softrst_i) begin
        m_cnt[n]   = 0;
        new_ovf[n] = 1'b0;
      end else begin
        if (we_i && int'(waddr_i) == n) begin
          m_cnt[n] = longint'(wdata_i);
        end else if (en_i && m_pending[n]) begin
          m_cnt[n] = m_cnt[n] + 1;
          if (m_cnt[n] >= (64'd1 << W)) begin
            m_cnt[n] = m_cnt[n] - (64'd1 << W);
            wrapped  = 1'b1;
          end
        end
        if (wrapped) new_ovf[n] = 1'b1;
        else if (ovf_clr_i[n]) new_ovf[n] = 1'b0;
      end
    end
    m_ovf     = new_ovf;
    m_intr    = new_intr;
    m_pending = softrst_i ? '0 : events_i;
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int n = 0; n < N; n++)
      check($sformatf("%s.cnt%0d", tag, n), 64'(counter_value_o[n]), m_cnt[n]);
    check({tag, ".ovf"}, 64'(overflow_o), 64'(m_ovf));
    check({tag, ".intr"}, 64'(intr_overflow_o), 64'(m_intr));
  endtask

  // driver: one clock edge, advance model, sample 1 time unit after the edge
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    softrst_i = 1'b0;
    events_i  = '0;
    we_i      = 1'b0;
    waddr_i   = '0;
    wdata_i   = '0;
    ovf_clr_i = '0;
  endtask

  task automatic write(input int addr, input logic [W-1:0] data, input string tag);
    we_i    = 1'b1;
    waddr_i = AW'(addr);
    wdata_i = data;
    step(tag);
    we_i    = 1'b0;
  endtask

  initial begin
    model_clear();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // basic count
    en_i = 1'b1;
    events_i = 9'b1;
    for (int i = 0; i < 5; i++) step("basic");
    events_i = '0;
    step("basic_tail");
    step("basic_tail");
    check("basic.cnt0_is_5", 64'(counter_value_o[0]), 64'd5);

    // wrap with mask set, then mask cleared
    ovf_mask_i = 9'b1 << 3;
    write(3, 32'hFFFF_FFFE, "wrap_wr");
    events_i = 9'b1 << 3;
    step("wrap_ev");
    step("wrap_ev");
    events_i = '0;
    step("wrap_hit");
    check("wrap.cnt3_zero", 64'(counter_value_o[3]), 64'd0);
    check("wrap.ovf3", 64'(overflow_o[3]), 64'd1);
    step("wrap_intr");
    check("wrap.intr_up", 64'(intr_overflow_o), 64'd1);
    ovf_mask_i = '0;
    step("wrap_nomask");
    step("wrap_nomask");
    ovf_clr_i = 9'b1 << 3;
    step("wrap_clr");
    ovf_clr_i = '0;

    // write beats coincident increment
    events_i = 9'b1 << 2;
    step("wve_ev");
    events_i = '0;
    write(2, 32'd100, "wve_wr");
    check("wve.cnt2_100", 64'(counter_value_o[2]), 64'd100);
    events_i = 9'b1 << 2;
    step("wve_ev2");
    events_i = '0;
    step("wve_inc");
    check("wve.cnt2_101", 64'(counter_value_o[2]), 64'd101);

    // clear coincident with wrap keeps the flag
    ovf_mask_i = 9'b1 << 1;
    write(1, 32'hFFFF_FFFF, "cvw_wr");
    events_i = 9'b1 << 1;
    step("cvw_ev");
    events_i  = '0;
    ovf_clr_i = 9'b1 << 1;
    step("cvw_wrap");
    check("cvw.ovf1_kept", 64'(overflow_o[1]), 64'd1);
    step("cvw_clr");
    check("cvw.ovf1_cleared", 64'(overflow_o[1]), 64'd0);
    ovf_clr_i = '0;
    step("cvw_intr_drop");
    check("cvw.intr_dropped", 64'(intr_overflow_o), 64'd0);

    // enable low discards events, bad addresses ignored
    en_i = 1'b0;
    events_i = '1;
    for (int i = 0; i < 3; i++) step("en_off");
    events_i = '0;
    step("en_off_drain");
    en_i = 1'b1;
    step("en_on");
    write(9, 32'hDEAD_BEEF, "bad_addr9");
    write(15, 32'h1234_5678, "bad_addr15");

    // soft reset with loaded counters, a set flag and an event in flight
    for (int n = 0; n < N; n++) write(n, 32'h100 + 32'(n), "sr_load");
    write(0, 32'hFFFF_FFFF, "sr_load0");
    ovf_mask_i = 9'b1;
    events_i = 9'b1;
    step("sr_wrap_ev");
    step("sr_wrap");
    softrst_i = 1'b1;
    step("softrst");
    softrst_i = 1'b0;
    events_i = '0;
    step("sr_after");
    step("sr_after");

    // asynchronous reset between edges
    for (int n = 0; n < N; n++) write(n, $urandom, "ar_load");
    write(4, 32'hFFFF_FFFF, "ar_load4");
    events_i = 9'b1 << 4;
    step("ar_ev");
    step("ar_wrap");
    events_i = '0;
    #2;
    rst_i = 1'b1;
    #1;
    model_clear();
    check_all("async_rst");
    #1;
    rst_i = 1'b0;
    step("ar_after");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      en_i       = ($urandom_range(0, 7) != 0);
      events_i   = N'($urandom);
      softrst_i  = ($urandom_range(0, 49) == 0);
      we_i       = ($urandom_range(0, 3) == 0);
      waddr_i    = AW'($urandom_range(0, (1 << AW) - 1));
      wdata_i    = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2))) : $urandom;
      ovf_clr_i  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      ovf_mask_i = N'($urandom);
      step("rand");
    end
    idle();
    step("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
